uart_rx_packet_parser: RTL and testbench

- Sequences the byte stream from the UART receiver: consumes one-cycle byte strobes and assembles framed packets.
- Frame format: SYNC, LEN, LEN payload bytes, CHK.
- A validated payload is held in an internal buffer and read out by the host through a random-access read port with an acknowledge handshake.
- Reports length, checksum, inter-byte timeout and overrun errors.
- Sits between the UART receiver and the command/register logic.

---
 rtl/uart_pkt_pkg.sv | 24 ++
 rtl/uart_pkt_timeout.sv | 26 ++
 rtl/uart_rx_packet_parser.sv | 134 +++++++++++++
 tb/tb_uart_rx_packet_parser.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared state and error encodings for the UART packet parser.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    READY   = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    BADLEN  = 3'd1,
    CHKSUM  = 3'd2,
    TIMEOUT = 3'd3,
    OVERRUN = 3'd4
  } err_e;

  function automatic logic len_ok(input logic [7:0] b, input logic [7:0] max_len);
    return (b != 8'd0) && (b <= max_len);
  endfunction

endpackage

// File: rtl/uart_pkt_timeout.sv
// Inter-byte idle counter: Expired pulses while enabled once TICKS-1 idle cycles elapse.
module uart_pkt_timeout #(
  parameter int TICKS = 1720
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  input  logic Clear,
  output logic Expired
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)                       cnt <= '0;
    else if (Clear)                   cnt <= '0;
    else if (Enable && cnt != LAST)   cnt <= cnt + CW'(1);
  end

  // Clear masks expiry so a byte landing on the expiry cycle wins.
  assign Expired = Enable && !Clear && (cnt == LAST);

endmodule

// File: rtl/uart_rx_packet_parser.sv
// Frames SYNC/LEN/payload/CHK packets from UART byte strobes into a host-readable buffer.
module uart_rx_packet_parser
  import uart_pkt_pkg::*;
#(
  parameter int         CLOCK_HZ     = 10_000_000,
  parameter int         BAUD         = 115200,
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_BITS = 20,
  localparam int        TIMEOUT_TICKS = (CLOCK_HZ / BAUD) * TIMEOUT_BITS,
  localparam int        LW = $clog2(MAX_LEN + 1),
  localparam int        AW = $clog2(MAX_LEN)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          ByteDone_i,
  input  logic [7:0]    Byte_i,
  input  logic [AW-1:0] RdAddr_i,
  output logic [7:0]    RdData_o,
  output logic          PacketReady_o,
  output logic [LW-1:0] PacketLen_o,
  input  logic          Ack_i,
  output logic          Error_o,
  output logic [2:0]    ErrorCode_o
);

  localparam logic [7:0] MAX_B = 8'(MAX_LEN);

  state_e        state, state_n;
  logic [LW-1:0] len, len_n, idx, idx_n;
  logic [7:0]    chk, chk_n;
  logic          err, err_n;
  err_e          code, code_n;
  logic          wr_en;
  logic          active, expired;
  logic [7:0]    buffer [MAX_LEN];

  assign active = (state == LEN) || (state == PAYLOAD) || (state == CHECK);

  uart_pkt_timeout #(.TICKS(TIMEOUT_TICKS)) u_timeout (
    .Clock   (Clock),
    .Reset   (Reset),
    .Enable  (active),
    .Clear   (ByteDone_i || !active),
    .Expired (expired)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      len   <= '0;
      idx   <= '0;
      chk   <= '0;
      err   <= 1'b0;
      code  <= NONE;
    end else begin
      state <= state_n;
      len   <= len_n;
      idx   <= idx_n;
      chk   <= chk_n;
      err   <= err_n;
      code  <= code_n;
    end
  end

  always_comb begin
    state_n = state;
    len_n   = len;
    idx_n   = idx;
    chk_n   = chk;
    err_n   = 1'b0;
    code_n  = code;
    wr_en   = 1'b0;
    case (state)
      IDLE: if (ByteDone_i && Byte_i == SYNC_BYTE) state_n = LEN;
      LEN: if (ByteDone_i) begin
        if (len_ok(Byte_i, MAX_B)) begin
          len_n   = Byte_i[LW-1:0];
          chk_n   = Byte_i;
          idx_n   = '0;
          state_n = PAYLOAD;
        end else begin
          err_n   = 1'b1;
          code_n  = BADLEN;
          state_n = IDLE;
        end
      end
      PAYLOAD: if (ByteDone_i) begin
        wr_en = 1'b1;
        chk_n = chk ^ Byte_i;
        idx_n = idx + LW'(1);
        if (idx + LW'(1) == len) state_n = CHECK;
      end
      CHECK: if (ByteDone_i) begin
        if (Byte_i == chk) state_n = READY;
        else begin
          err_n   = 1'b1;
          code_n  = CHKSUM;
          state_n = IDLE;
        end
      end
      READY: begin
        // A byte arriving with the release is treated as the first byte after IDLE.
        if (Ack_i) state_n = (ByteDone_i && Byte_i == SYNC_BYTE) ? LEN : IDLE;
        else if (ByteDone_i) begin
          err_n  = 1'b1;
          code_n = OVERRUN;
        end
      end
      default: state_n = IDLE;
    endcase
    if (expired) begin
      err_n   = 1'b1;
      code_n  = TIMEOUT;
      state_n = IDLE;
    end
  end

  always_ff @(posedge Clock) begin
    if (wr_en) buffer[idx[AW-1:0]] <= Byte_i;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) RdData_o <= 8'h00;
    else if (state == READY && LW'(RdAddr_i) < len) RdData_o <= buffer[RdAddr_i];
    else RdData_o <= 8'h00;
  end

  assign PacketReady_o = (state == READY);
  assign PacketLen_o   = (state == READY) ? len : '0;
  assign Error_o       = err;
  assign ErrorCode_o   = code;

endmodule

// File: tb/tb_uart_rx_packet_parser.sv
// Scoreboarded bench: frame events are queued when driven and retired as the parser reports them.
module tb_uart_rx_packet_parser;

  localparam int MAX_LEN = 16;
  localparam int CLK_HZ  = 1_000_000;
  localparam int BAUD_R  = 100_000;
  localparam int TO_BITS = 3;
  localparam int TO      = (CLK_HZ / BAUD_R) * TO_BITS;
  localparam int AW      = 4;
  localparam int LW      = 5;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          ByteDone_i = 1'b0;
  logic [7:0]    Byte_i = 8'h00;
  logic [AW-1:0] RdAddr_i = '0;
  logic          Ack_i = 1'b0;
  logic [7:0]    RdData_o;
  logic          PacketReady_o;
  logic [LW-1:0] PacketLen_o;
  logic          Error_o;
  logic [2:0]    ErrorCode_o;

  int n_chk = 0;
  int n_err = 0;

  // kind: 1 = packet ready, 2 = error pulse
  typedef struct { int kind; int code; int len; } exp_t;
  exp_t sb[$];

  uart_rx_packet_parser #(
    .CLOCK_HZ(CLK_HZ), .BAUD(BAUD_R), .MAX_LEN(MAX_LEN),
    .SYNC_BYTE(8'hA5), .TIMEOUT_BITS(TO_BITS)
  ) dut (
    .Clock(Clock), .Reset(Reset), .ByteDone_i(ByteDone_i), .Byte_i(Byte_i),
    .RdAddr_i(RdAddr_i), .RdData_o(RdData_o), .PacketReady_o(PacketReady_o),
    .PacketLen_o(PacketLen_o), .Ack_i(Ack_i), .Error_o(Error_o), .ErrorCode_o(ErrorCode_o)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Retire scoreboard entries on DUT events, away from the active edge.
  logic rdy_q = 1'b0, err_q = 1'b0;
  always @(negedge Clock) begin
    exp_t e;
    if (Error_o || (PacketReady_o && !rdy_q)) begin
      e = '{kind: 0, code: 0, len: 0};
      if (sb.size() != 0) e = sb.pop_front();
      chk("evt_kind", Error_o ? 32'd2 : 32'd1, e.kind);
      if (Error_o) begin
        chk("err_code", {29'd0, ErrorCode_o}, e.code);
        chk("err_one_cycle", {31'd0, err_q}, 32'd0);
      end else begin
        chk("pkt_len", {27'd0, PacketLen_o}, e.len);
      end
    end
    rdy_q <= PacketReady_o;
    err_q <= Error_o;
  end

  task automatic exp_pkt(input int len);
    sb.push_back('{kind: 1, code: 0, len: len});
  endtask

  task automatic exp_err(input int code);
    sb.push_back('{kind: 2, code: code, len: 0});
  endtask

  task automatic send_byte(input logic [7:0] b);
    ByteDone_i = 1'b1;
    Byte_i     = b;
    @(posedge Clock); #1;
    ByteDone_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] bs[$]);
    foreach (bs[i]) send_byte(bs[i]);
  endtask

  task automatic read_chk(input string tag, input int a, input logic [7:0] d);
    RdAddr_i = AW'(a);
    @(posedge Clock); #1;
    chk(tag, {24'd0, RdData_o}, {24'd0, d});
  endtask

  task automatic ack();
    Ack_i = 1'b1;
    @(posedge Clock); #1;
    Ack_i = 1'b0;
    chk("ack_drops_ready", {31'd0, PacketReady_o}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"},  {31'd0, PacketReady_o}, 32'd0);
    chk({tag, "_len"},  {27'd0, PacketLen_o}, 32'd0);
    chk({tag, "_err"},  {31'd0, Error_o}, 32'd0);
    chk({tag, "_code"}, {29'd0, ErrorCode_o}, 32'd0);
    chk({tag, "_rd"},   {24'd0, RdData_o}, 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    repeat (3) @(posedge Clock); #1;
    chk_all_zero("reset");
    Reset = 1'b1;
    @(posedge Clock); #1;

    // Valid frame, readback including past-length address
    exp_pkt(3);
    q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send(q);
    chk("A_ready", {31'd0, PacketReady_o}, 32'd1);
    chk("A_len", {27'd0, PacketLen_o}, 32'd3);
    read_chk("A_rd0", 0, 8'h11);
    read_chk("A_rd1", 1, 8'h22);
    read_chk("A_rd2", 2, 8'h33);
    read_chk("A_rd3", 3, 8'h00);

    // Overrun while held; buffer must survive
    exp_err(4);
    send_byte(8'h55);
    chk("ovr_code", {29'd0, ErrorCode_o}, 32'd4);
    chk("ovr_ready_held", {31'd0, PacketReady_o}, 32'd1);
    read_chk("ovr_rd0", 0, 8'h11);
    read_chk("ovr_rd2", 2, 8'h33);

    // Ack together with SYNC starts the next frame
    Ack_i = 1'b1; ByteDone_i = 1'b1; Byte_i = 8'hA5;
    @(posedge Clock); #1;
    Ack_i = 1'b0; ByteDone_i = 1'b0;
    chk("acksync_rdy", {31'd0, PacketReady_o}, 32'd0);
    chk("acksync_noerr", {31'd0, Error_o}, 32'd0);
    exp_pkt(1);
    q = '{8'h01, 8'h7E, 8'h7F};
    send(q);
    chk("B_ready", {31'd0, PacketReady_o}, 32'd1);
    read_chk("B_rd0", 0, 8'h7E);
    read_chk("B_rd1", 1, 8'h00);
    ack();
    read_chk("idle_rd0", 0, 8'h00);

    // Bad checksum, then a good frame
    exp_err(2);
    q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hFF};
    send(q);
    chk("chk_code", {29'd0, ErrorCode_o}, 32'd2);
    chk("chk_no_ready", {31'd0, PacketReady_o}, 32'd0);
    exp_pkt(1);
    q = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
    send(q);
    read_chk("C_rd0", 0, 8'h5A);
    ack();

    // Length errors and discarded garbage
    exp_err(1);
    q = '{8'hA5, 8'h00};
    send(q);
    chk("len0_code", {29'd0, ErrorCode_o}, 32'd1);
    exp_err(1);
    q = '{8'hA5, 8'h11};
    send(q);
    chk("len17_code", {29'd0, ErrorCode_o}, 32'd1);
    exp_pkt(16);
    q = '{8'h00, 8'hFF, 8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) q.push_back(8'(i * 7 + 1));
    begin
      logic [7:0] x;
      x = 8'h10;
      for (int i = 0; i < 16; i++) x ^= 8'(i * 7 + 1);
      q.push_back(x);
    end
    send(q);
    chk("garbage_code_held", {29'd0, ErrorCode_o}, 32'd1);
    chk("max_len", {27'd0, PacketLen_o}, 32'd16);
    read_chk("max_rd15", 15, 8'(15 * 7 + 1));
    ack();

    // Timeout fires exactly TO cycles after the last strobe edge
    exp_err(3);
    q = '{8'hA5, 8'h02, 8'h10};
    send(q);
    repeat (TO - 1) @(posedge Clock);
    #1;
    chk("to_early", {31'd0, Error_o}, 32'd0);
    @(posedge Clock); #1;
    chk("to_fire", {31'd0, Error_o}, 32'd1);
    chk("to_code", {29'd0, ErrorCode_o}, 32'd3);
    exp_pkt(1);
    q = '{8'hA5, 8'h01, 8'h44, 8'h45};
    send(q);
    read_chk("D_rd0", 0, 8'h44);
    ack();

    // Bytes one cycle before expiry and on the expiry cycle both win
    exp_pkt(2);
    q = '{8'hA5, 8'h02, 8'h10};
    send(q);
    repeat (TO - 2) @(posedge Clock);
    #1;
    send_byte(8'h20);
    repeat (TO - 1) @(posedge Clock);
    #1;
    send_byte(8'h32);
    chk("near_ready", {31'd0, PacketReady_o}, 32'd1);
    chk("near_code_held", {29'd0, ErrorCode_o}, 32'd3);
    read_chk("near_rd1", 1, 8'h20);
    ack();

    // Reset mid-frame
    q = '{8'hA5, 8'h02, 8'h10};
    send(q);
    Reset = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    exp_pkt(2);
    q = '{8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h64};
    send(q);
    chk("E_ready", {31'd0, PacketReady_o}, 32'd1);
    read_chk("E_rd0", 0, 8'hAB);
    read_chk("E_rd1", 1, 8'hCD);
    ack();

    repeat (2) @(posedge Clock);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
